// File: rtl/imem_boot_ctrl_if.sv
// Program-load stream and instruction-memory write port of the boot controller.
// The controller connects through the master modport; the producer/memory side
// (or a testbench) uses the slave modport.
interface imem_boot_ctrl_if #(
   parameter int INSTRUCTION = 32,
   parameter int ADDR_W      = 8
);
   logic                   in_valid;
   logic [INSTRUCTION-1:0] in_data;
   logic                   in_ready;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [INSTRUCTION-1:0] mem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams a program image into instruction memory while the
// core is held in reset, waits a settle delay, then releases the core and
// hands the memory address port to the core PC, flagging bad fetch addresses.
module imem_boot_ctrl #(
   parameter int INSTRUCTION = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int RUN_DELAY   = 4
) (
   input  logic                   clk,
   input  logic                   rst,          // asynchronous, active low
   input  logic                   i_start,
   input  logic                   i_halt,
   input  logic [ADDR_W:0]        i_word_count,
   input  logic [INSTRUCTION-1:0] i_pc_address,
   output logic                   o_core_rst_n,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err,
   output logic                   o_pc_fault,
   imem_boot_ctrl_if.master       bus
);

   localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      RUN_DELAY_C = 4'(RUN_DELAY);
   localparam int              PAD_W       = INSTRUCTION - ADDR_W - 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W:0]   r_load_cnt;
   logic [ADDR_W:0]   r_count_lat;
   logic [3:0]        r_delay;
   logic              r_pc_fault;

   logic              w_start_ok;
   logic              w_accept_start;
   logic              w_handshake;
   logic              w_last;
   logic              w_fetch_bad;

   // A start is legal only for a non-empty image that fits in memory.
   assign w_start_ok     = i_start && (i_word_count != '0) && (i_word_count <= DEPTH_C);
   assign w_accept_start = !i_halt && w_start_ok && (r_state == S_IDLE || r_state == S_ERR);
   // halt blocks the handshake so a halted cycle never writes.
   assign w_handshake    = (r_state == S_LOAD) && bus.in_valid && !i_halt;
   assign w_last         = (r_load_cnt == r_count_lat - 1'b1);
   // Word index is compared at full PC width so high PC bits cannot alias into range.
   assign w_fetch_bad    = (i_pc_address[1:0] != 2'b00) ||
                           ({{PAD_W{1'b0}}, r_count_lat} <= i_pc_address[INSTRUCTION-1:2]);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state decode; halt overrides everything.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next_state = w_start_ok ? S_LOAD : S_ERR;
         S_LOAD:   if (w_handshake && w_last) w_next_state = S_SETTLE;
         S_SETTLE: if (r_delay <= 4'd1) w_next_state = S_RUN;
         S_RUN:    w_next_state = S_RUN;
         S_ERR:    if (w_start_ok) w_next_state = S_LOAD;
         default:  w_next_state = S_IDLE;
      endcase
      if (i_halt) w_next_state = S_IDLE;
   end

   // Load counter, latched count, settle delay and sticky fetch fault.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_load_cnt  <= '0;
         r_count_lat <= '0;
         r_delay     <= '0;
         r_pc_fault  <= 1'b0;
      end else begin
         if (w_accept_start) begin
            r_load_cnt  <= '0;
            r_count_lat <= i_word_count;
            r_pc_fault  <= 1'b0;
         end
         if (w_handshake) begin
            r_load_cnt <= r_load_cnt + 1'b1;
            if (w_last) r_delay <= RUN_DELAY_C;
         end
         if (r_state == S_SETTLE && r_delay != 4'd0) r_delay <= r_delay - 1'b1;
         if (r_state == S_RUN && w_fetch_bad) r_pc_fault <= 1'b1;
      end
   end

   // Output decode from the registered state (write path also gated by halt).
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      o_core_rst_n  = 1'b0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_err         = 1'b0;
      case (r_state)
         S_LOAD: begin
            bus.in_ready  = !i_halt;
            bus.mem_we    = bus.in_valid && !i_halt;
            bus.mem_addr  = r_load_cnt[ADDR_W-1:0];
            bus.mem_wdata = bus.in_data;
            o_busy        = 1'b1;
         end
         S_SETTLE: o_busy = 1'b1;
         S_RUN: begin
            o_core_rst_n = 1'b1;
            o_done       = 1'b1;
            bus.mem_addr = i_pc_address[ADDR_W+1:2];
         end
         S_ERR:   o_err = 1'b1;
         default: ;
      endcase
   end

   assign o_pc_fault = r_pc_fault;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: expected memory writes are queued as words are
// driven and checked by a write monitor; control outputs are checked inline.
module tb_imem_boot_ctrl;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic        i_halt = 1'b0;
   logic [8:0]  i_word_count = '0;
   logic [31:0] i_pc_address = '0;
   logic        o_core_rst_n, o_busy, o_done, o_err, o_pc_fault;

   int n_vec = 0;
   int n_err = 0;
   wr_t exp_q[$];
   logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00208113, 32'h0000006F};

   always #5 clk = ~clk;

   imem_boot_ctrl_if #(.INSTRUCTION(32), .ADDR_W(8)) bus ();

   imem_boot_ctrl #(.INSTRUCTION(32), .ADDR_W(8), .DEPTH(256), .RUN_DELAY(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_halt       (i_halt),
      .i_word_count (i_word_count),
      .i_pc_address (i_pc_address),
      .o_core_rst_n (o_core_rst_n),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err),
      .o_pc_fault   (o_pc_fault),
      .bus          (bus)
   );

   // Write monitor: every memory write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && bus.mem_we) begin
         wr_t e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: addr=%0d data=%h, required no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
               n_err++;
               $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                        bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end else
               $display("write addr=%0d data=%h ok", bus.mem_addr, bus.mem_wdata);
         end
      end
   end

   task automatic do_start(input int n);
      @(posedge clk); #1;
      i_start = 1'b1; i_word_count = 9'(n);
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      i_halt = 1'b1;
      @(posedge clk); #1;
      i_halt = 1'b0;
   endtask

   // Drive n words; toggle inserts an idle (invalid) cycle between words.
   task automatic stream(input int n, input bit toggle, input bit rnd);
      logic [31:0] d;
      logic [7:0]  a;
      wr_t w;
      for (int i = 0; i < n; i++) begin
         d = rnd ? $urandom : prog[i % 4];
         a = 8'(i);
         w.addr = a; w.data = d;
         exp_q.push_back(w);
         bus.in_valid = 1'b1; bus.in_data = d;
         @(posedge clk); #1;
         if (toggle && i != n - 1) begin
            bus.in_valid = 1'b0; bus.in_data = 32'hDEADBEEF;
            @(posedge clk); #1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_run();
      int k = 0;
      while (!o_done && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      n_vec++;
      if (!o_done) begin
         n_err++;
         $display("FAIL wait_run: done=%b after %0d cycles, required 1", o_done, k);
      end
   endtask

   task automatic check_q_empty(input string name);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_missing_writes: %0d pending, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if ({o_core_rst_n, o_busy, o_done, o_err, o_pc_fault, bus.in_ready, bus.mem_we} !== 7'b0 ||
          bus.mem_addr !== 8'd0 || bus.mem_wdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_outputs: rstn=%b busy=%b done=%b err=%b flt=%b rdy=%b we=%b addr=%0d, required all 0",
                  o_core_rst_n, o_busy, o_done, o_err, o_pc_fault, bus.in_ready, bus.mem_we, bus.mem_addr);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (o_busy !== 1'b0 || o_core_rst_n !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: busy=%b core_rst_n=%b, required 0 0", o_busy, o_core_rst_n);
      end
      $display("test_reset done");
   endtask

   task automatic test_load_contig();
      do_start(4);
      n_vec++;
      if (o_busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL load_entry: busy=%b in_ready=%b, required 1 1", o_busy, bus.in_ready);
      end
      stream(4, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (o_busy !== 1'b1 || o_done !== 1'b0 || o_core_rst_n !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL settle_cycle%0d: busy=%b done=%b core_rst_n=%b rdy=%b, required 1 0 0 0",
                     k, o_busy, o_done, o_core_rst_n, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if (o_done !== 1'b1 || o_core_rst_n !== 1'b1 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL run_entry: done=%b core_rst_n=%b busy=%b, required 1 1 0", o_done, o_core_rst_n, o_busy);
      end
      i_pc_address = 32'h8; #1;
      n_vec++;
      if (bus.mem_addr !== 8'd2) begin
         n_err++;
         $display("FAIL run_pc_addr: mem_addr=%0d, required 2", bus.mem_addr);
      end
      check_q_empty("contig");
      $display("test_load_contig done");
   endtask

   task automatic test_load_toggle();
      go_idle();
      do_start(4);
      stream(4, 1'b1, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      wait_run();
      check_q_empty("toggle");
      $display("test_load_toggle done");
   endtask

   task automatic test_err();
      go_idle();
      do_start(0);
      n_vec++;
      if (o_err !== 1'b1 || o_core_rst_n !== 1'b0) begin
         n_err++;
         $display("FAIL err_zero: err=%b core_rst_n=%b, required 1 0", o_err, o_core_rst_n);
      end
      do_start(257);
      n_vec++;
      if (o_err !== 1'b1 || o_core_rst_n !== 1'b0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL err_257: err=%b core_rst_n=%b busy=%b, required 1 0 0", o_err, o_core_rst_n, o_busy);
      end
      do_start(2);
      n_vec++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL err_recover: err=%b busy=%b, required 0 1", o_err, o_busy);
      end
      stream(2, 1'b0, 1'b1);
      wait_run();
      check_q_empty("err");
      $display("test_err done");
   endtask

   task automatic test_pc_fault();
      go_idle();
      do_start(4);
      stream(4, 1'b0, 1'b1);
      wait_run();
      i_pc_address = 32'hC;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b0) begin
         n_err++;
         $display("FAIL pc_last_word: pc_fault=%b, required 0", o_pc_fault);
      end
      i_pc_address = 32'h10;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b1) begin
         n_err++;
         $display("FAIL pc_out_of_image: pc_fault=%b, required 1", o_pc_fault);
      end
      i_pc_address = 32'h4;
      @(posedge clk); #1;
      i_pc_address = 32'h2;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b1) begin
         n_err++;
         $display("FAIL pc_sticky: pc_fault=%b, required 1", o_pc_fault);
      end
      go_idle();
      i_pc_address = 32'h0;
      do_start(1);
      n_vec++;
      if (o_pc_fault !== 1'b0) begin
         n_err++;
         $display("FAIL pc_clear_on_start: pc_fault=%b, required 0", o_pc_fault);
      end
      stream(1, 1'b0, 1'b1);
      wait_run();
      i_pc_address = 32'h1;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b1) begin
         n_err++;
         $display("FAIL pc_misaligned: pc_fault=%b, required 1", o_pc_fault);
      end
      i_pc_address = 32'h0;
      check_q_empty("pcfault");
      $display("test_pc_fault done");
   endtask

   task automatic test_halt();
      wr_t w;
      go_idle();
      do_start(4);
      stream(1, 1'b0, 1'b0);
      bus.in_valid = 1'b1; bus.in_data = prog[1]; i_halt = 1'b1; #1;
      n_vec++;
      if (bus.mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL halt_no_write: mem_we=%b, required 0", bus.mem_we);
      end
      @(posedge clk); #1;
      i_halt = 1'b0; bus.in_valid = 1'b0;
      n_vec++;
      if (o_busy !== 1'b0 || o_core_rst_n !== 1'b0 || o_err !== 1'b0) begin
         n_err++;
         $display("FAIL halt_idle: busy=%b core_rst_n=%b err=%b, required 0 0 0", o_busy, o_core_rst_n, o_err);
      end
      do_start(3);
      stream(3, 1'b0, 1'b1);
      wait_run();
      check_q_empty("halt");
      w = '0;
      $display("test_halt done%s", (w.addr == 8'd0) ? "" : "?");
   endtask

   task automatic test_full_depth();
      go_idle();
      do_start(256);
      stream(256, 1'b0, 1'b1);
      wait_run();
      i_pc_address = 32'h3FC;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b0 || bus.mem_addr !== 8'd255) begin
         n_err++;
         $display("FAIL full_last_word: pc_fault=%b addr=%0d, required 0 255", o_pc_fault, bus.mem_addr);
      end
      i_pc_address = 32'h400;
      @(posedge clk); #1;
      n_vec++;
      if (o_pc_fault !== 1'b1) begin
         n_err++;
         $display("FAIL full_past_end: pc_fault=%b, required 1", o_pc_fault);
      end
      i_pc_address = 32'h0;
      check_q_empty("full");
      $display("test_full_depth done");
   endtask

   task automatic test_async_reset();
      go_idle();
      do_start(2);
      stream(2, 1'b0, 1'b1);
      @(posedge clk); #3;
      rst = 1'b0; #1;
      n_vec++;
      if ({o_core_rst_n, o_busy, o_done, o_err, o_pc_fault, bus.in_ready, bus.mem_we} !== 7'b0 ||
          bus.mem_addr !== 8'd0) begin
         n_err++;
         $display("FAIL async_reset: rstn=%b busy=%b done=%b err=%b flt=%b rdy=%b we=%b addr=%0d, required all 0",
                  o_core_rst_n, o_busy, o_done, o_err, o_pc_fault, bus.in_ready, bus.mem_we, bus.mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_vec++;
      if (o_done !== 1'b0 || o_core_rst_n !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset_stays_idle: done=%b core_rst_n=%b, required 0 0", o_done, o_core_rst_n);
      end
      check_q_empty("async");
      $display("test_async_reset done");
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_load_contig();
      test_load_toggle();
      test_err();
      test_pc_fault();
      test_halt();
      test_full_depth();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot and sequencing controller for the instruction memory and processor core. It accepts a program image word by word over a valid/ready stream and writes it into consecutive instruction-memory locations while holding the core in reset. After a settle delay it releases the core and hands the memory address port to the core's PC. It also flags out-of-image or misaligned fetch addresses.

Parameters:
INSTRUCTION, 32, instruction/data word width
ADDR_W, 8, instruction-memory word-address width (word address = byte address [ADDR_W+1:2])
DEPTH, 256, instruction-memory depth in words (must be at most 2**ADDR_W)
RUN_DELAY, 4, cycles the core is held in reset after the last write (range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load; latches word_count
halt  in  1  return to IDLE and hold the core in reset
word_count  in  ADDR_W+1  number of words to load, legal range 1..DEPTH
in_valid  in  1  program word available
in_data  in  INSTRUCTION  program word
in_ready  out  1  controller accepts in_data this cycle
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  instruction-memory word address
mem_wdata  out  INSTRUCTION  instruction-memory write data
pc_address  in  INSTRUCTION  core byte PC
core_rst_n  out  1  active-low core reset (0 = core held)
busy  out  1  high in LOAD or SETTLE
done  out  1  high in RUN
err  out  1  high in ERR
pc_fault  out  1  sticky fetch fault

Behaviour:
- Reset (rst=0, async): state=IDLE, load count=0, latched count=0, delay counter=0, pc_fault=0. Outputs in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0.
- States: IDLE, LOAD, SETTLE, RUN, ERR. All state outputs are decoded from the registered state.
- IDLE:
  - start with word_count in 1..DEPTH: latch the count, clear the load counter and pc_fault, go to LOAD.
  - start with word_count=0 or word_count>DEPTH: go to ERR.
- LOAD:
  - in_ready=1. mem_we=in_valid (combinational), mem_addr=load counter, mem_wdata=in_data.
  - A write occurs in the same cycle as the handshake. The counter increments on each handshake.
  - Handshake while counter = latched count-1: go to SETTLE and load the delay counter with RUN_DELAY.
  - in_valid low: the state holds indefinitely with no write.
  - start is ignored in LOAD.
- SETTLE:
  - in_ready=0, mem_we=0, core_rst_n=0. The delay counter decrements each cycle.
  - When the counter reaches 1, go to RUN. The core is held exactly RUN_DELAY cycles after the last write.
- RUN:
  - core_rst_n=1, mem_we=0, mem_addr=pc_address[ADDR_W+1:2], done=1.
  - pc_fault is set (sticky) on any cycle where pc_address[1:0]!=0 or pc_address[INSTRUCTION-1:2] >= latched count.
  - start in RUN is ignored.
- ERR: err=1, core_rst_n=0. A valid start goes to LOAD, same as from IDLE. An invalid start stays in ERR.
- Outside LOAD and RUN, mem_addr is 0.
- halt: has priority over start and over any handshake in the same cycle. Next state is IDLE from any state. No write occurs in that cycle (mem_we is forced 0). core_rst_n goes 0 from the next cycle.
- halt mid-load: the partial image remains in memory, and the load counter resets on the next start.
- Counter widths: the load counter is ADDR_W+1 bits wide, and the compare uses the latched count. When word_count=DEPTH=2**ADDR_W, the last address is DEPTH-1 and there is no wrap.

Test Plan:
- Load 4 words (0x00000013, 0x00100093, 0x00208113, 0x0000006F) with in_valid held high -> mem_we high for 4 consecutive cycles at addr 0..3. SETTLE lasts 4 cycles, then core_rst_n=1 and done=1. mem_addr follows pc_address 0x8 -> 2.
- Same 4-word load with in_valid toggled 1,0,1,0... -> writes only on valid cycles, addresses contiguous 0..3, and no extra writes occur.
- start with word_count=0, then 257 -> err=1 and core_rst_n stays 0. Then start with 2 -> LOAD, err=0.
- In RUN after a 4-word load, drive pc_address=0x10 -> pc_fault=1 and it stays set. Then drive pc_address=0x2 -> pc_fault remains 1. A new start clears it.
- halt asserted together with a valid handshake on the 2nd word -> no write that cycle, state=IDLE. A following start of 3 words writes addr 0..2.
- Assert rst=0 asynchronously mid-SETTLE -> all outputs go to their reset values immediately, with core_rst_n=0.
